// File: rtl/mem_arb_pkg.sv
// Shared constants, master indices and write-mask legality rule for the
// two-master memory arbiter.
package mem_arb_pkg;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  localparam int M_IF = 0;
  localparam int M_LS = 1;

  typedef enum logic [0:0] {
    IDX_IF = 1'b0,
    IDX_LS = 1'b1
  } master_e;

  // A write mask is legal only when it names a naturally aligned byte,
  // halfword or word starting at the byte offset given by the address.
  function automatic logic mask_legal(input logic [3:0] wmask, input logic [1:0] ofs);
    logic ok;
    ok = 1'b0;
    case (wmask)
      MASK_B:  ok = (ofs == 2'd0);
      4'b0010: ok = (ofs == 2'd1);
      4'b0100: ok = (ofs == 2'd2);
      4'b1000: ok = (ofs == 2'd3);
      MASK_H:  ok = (ofs == 2'd0);
      4'b1100: ok = (ofs == 2'd2);
      MASK_W:  ok = (ofs == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on ties when fair=1, fixed priority to the
// load/store master otherwise. Owns the last-grant history.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  input  logic       fair,
  output logic [1:0] grant
);

  master_e last_reg;

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      if (fair && (last_reg == IDX_LS)) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end
  end

  // Reset to the load/store index so instruction fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= IDX_LS;
    end else if (grant[M_LS]) begin
      last_reg <= IDX_LS;
    end else if (grant[M_IF]) begin
      last_reg <= IDX_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between instruction fetch (m0) and
// load/store (m1) with one-cycle registered responses per master.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_wen,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_wen,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        req_valid;
  logic [1:0]        req_wen;
  logic [1:0]        rsp_ready_vec;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [3:0]        req_wmask [2];

  assign req_valid     = {m1_req_valid, m0_req_valid};
  assign req_wen       = {m1_wen, m0_wen};
  assign rsp_ready_vec = {m1_rsp_ready, m0_rsp_ready};
  assign req_addr[M_IF]  = m0_addr;
  assign req_addr[M_LS]  = m1_addr;
  assign req_wdata[M_IF] = m0_wdata;
  assign req_wdata[M_LS] = m1_wdata;
  assign req_wmask[M_IF] = m0_wmask;
  assign req_wmask[M_LS] = m1_wmask;

  logic [1:0]        elig;
  logic [1:0]        grant;
  logic              rsp_valid_reg [2];
  logic [DATA_W-1:0] rdata_reg     [2];
  logic              err_reg       [2];

  // A master is eligible only if its response slot is free or drains now;
  // reset suppresses every grant so nothing is accepted or written.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = rst_n && req_valid[gi] &&
                        (!rsp_valid_reg[gi] || rsp_ready_vec[gi]);
    end
  endgenerate

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .elig  (elig),
    .fair  (FAIR != 0),
    .grant (grant)
  );

  logic sel;
  logic granted;
  logic legal;

  assign sel     = grant[M_LS];
  assign granted = |grant;
  assign legal   = mask_legal(req_wmask[sel], req_addr[sel][1:0]);

  assign mem_addr  = {req_addr[sel][ADDR_W-1:2], 2'b00};
  assign mem_wdata = req_wdata[sel];
  assign mem_wmask = granted ? req_wmask[sel] : 4'b0000;
  assign mem_wen   = granted && req_wen[sel] && legal;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rsp_valid_reg[gi] <= 1'b0;
          rdata_reg[gi]     <= '0;
          err_reg[gi]       <= 1'b0;
        end else if (grant[gi]) begin
          // A new accept overrides a simultaneous drain of the old response.
          rsp_valid_reg[gi] <= 1'b1;
          rdata_reg[gi]     <= req_wen[gi] ? '0 : mem_rdata;
          err_reg[gi]       <= req_wen[gi] && !legal;
        end else if (rsp_ready_vec[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign m0_req_ready = grant[M_IF];
  assign m1_req_ready = grant[M_LS];
  assign m0_rsp_valid = rsp_valid_reg[M_IF];
  assign m1_rsp_valid = rsp_valid_reg[M_LS];
  assign m0_rdata     = rdata_reg[M_IF];
  assign m1_rdata     = rdata_reg[M_LS];
  assign m0_err       = err_reg[M_IF];
  assign m1_err       = err_reg[M_LS];

endmodule
